// File: rtl/image_pass_scheduler.sv
// image_pass_scheduler: shares the single image BRAM port between display reads (strict priority)
// and a background transform frame pass. Optional stall statistics are enabled by PASS_STATS_EN.

module image_pass_scheduler #(
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 24,
   parameter int FRAME_WORDS = 76800,
   parameter int WQ_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [DATA_W-1:0] xf_in_data,
   output logic              xf_in_valid,
   input  logic [DATA_W-1:0] xf_out_data,
   input  logic              xf_out_valid,
   output logic [31:0]       stall_cnt
);

   localparam int QI_W  = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
   localparam int CNT_W = $clog2(WQ_DEPTH + 1);
   localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);
   localparam logic [CNT_W:0]    CREDITS   = (CNT_W + 1)'(WQ_DEPTH);
   localparam logic [QI_W-1:0]   QI_LAST   = QI_W'(WQ_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [QI_W-1:0]   head_q, head_d;
   logic [QI_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic              err_q, err_d;
   logic              disp_pend_q, disp_pend_d;
   logic              eng_pend_q, eng_pend_d;

   logic [ADDR_W-1:0] wq_addr_q [WQ_DEPTH];
   logic [DATA_W-1:0] wq_data_q [WQ_DEPTH];

   logic q_empty, q_full, rd_eligible;
   logic grant_disp, grant_wr, grant_rd;
   logic push_ok, inflight_dec;

   // Port arbitration: display, then queued write-back, then a credit-limited engine read.
   always_comb begin
      q_empty     = (count_q == '0);
      q_full      = (count_q == CNT_W'(WQ_DEPTH));
      rd_eligible = (state_q == S_RUN) && (rd_ptr_q < FRAME_END) &&
                    (({1'b0, count_q} + {1'b0, inflight_q}) < CREDITS);
      grant_disp  = !rst && disp_req;
      grant_wr    = !rst && !disp_req && !q_empty;
      grant_rd    = !rst && !disp_req && q_empty && rd_eligible;

      mem_en   = grant_disp || grant_wr || grant_rd;
      mem_we   = grant_wr;
      mem_addr = '0;
      mem_din  = '0;
      if (grant_disp) begin
         mem_addr = disp_addr;
      end else if (grant_wr) begin
         mem_addr = wq_addr_q[head_q];
         mem_din  = wq_data_q[head_q];
      end else if (grant_rd) begin
         mem_addr = rd_ptr_q;
      end
   end

   assign disp_valid = disp_pend_q;
   assign disp_data  = disp_pend_q ? mem_dout : '0;
   assign xf_in_valid = eng_pend_q;
   assign xf_in_data  = eng_pend_q ? mem_dout : '0;
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign err  = err_q;

   // A result arriving with the queue full is dropped but still returns its credit.
   always_comb begin
      push_ok      = xf_out_valid && !q_full;
      inflight_dec = xf_out_valid && (inflight_q != '0);

      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      inflight_d  = inflight_q;
      err_d       = err_q || (xf_out_valid && q_full);
      disp_pend_d = grant_disp;
      eng_pend_d  = grant_rd;

      if (grant_wr)
         head_d = (head_q == QI_LAST) ? '0 : head_q + QI_W'(1);
      if (push_ok) begin
         tail_d = (tail_q == QI_LAST) ? '0 : tail_q + QI_W'(1);
         if (wr_ptr_q != FRAME_END)
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      case ({push_ok, grant_wr})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      case ({grant_rd, inflight_dec})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
      if (grant_rd)
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (rd_ptr_q == FRAME_END) state_d = S_DRAIN;
         S_DRAIN: if ((inflight_q == '0) && q_empty) state_d = S_DONE;
         S_DONE: begin
            state_d  = S_IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         inflight_q  <= '0;
         err_q       <= 1'b0;
         disp_pend_q <= 1'b0;
         eng_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         err_q       <= err_d;
         disp_pend_q <= disp_pend_d;
         eng_pend_q  <= eng_pend_d;
      end
   end

   // Queue storage needs no reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         wq_addr_q[tail_q] <= wr_ptr_q;
         wq_data_q[tail_q] <= xf_out_data;
      end
   end

`ifdef PASS_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Counts pass cycles where the engine had port work but the display took the port.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == S_IDLE) && start)
         stall_cnt_d = '0;
      else if (((state_q == S_RUN) || (state_q == S_DRAIN)) && disp_req &&
               (!q_empty || rd_eligible) && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: doc/image_pass_scheduler.md
Name: image_pass_scheduler

Overview:
- Owns the single read/write port of the image BRAM and shares it between two requesters: the VGA pixel fetch, which has strict priority, and a background frame-pass engine.
- The frame-pass engine streams every image word through the external pixel transform pipeline (encryption/decryption) and writes the result back in place.
- It uses only the port cycles the display leaves free, mainly during blanking.
- It sits between the VGA image fetch logic, the BRAM and the transform pipeline, all in the 25 MHz pixel clock domain.

Parameters:
- ADDR_W, 18, BRAM address width.
- DATA_W, 24, pixel word width (RGB888).
- FRAME_WORDS, 76800, number of words processed per pass (addresses 0..FRAME_WORDS-1).
- WQ_DEPTH, 4, write-back queue depth; also the cap on outstanding pass words.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame pass.
- busy  out  1  high while a pass is active.
- done  out  1  one-cycle pulse when a pass completes.
- err  out  1  sticky; transform result arrived with the queue full.
- disp_req  in  1  display read request (video-on qualified).
- disp_addr  in  ADDR_W  display read address.
- disp_data  out  DATA_W  display read data.
- disp_valid  out  1  disp_data valid.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_din  out  DATA_W  BRAM write data.
- mem_dout  in  DATA_W  BRAM read data; 1-cycle latency.
- xf_in_data  out  DATA_W  word sent to the transform pipeline.
- xf_in_valid  out  1  xf_in_data valid.
- xf_out_data  in  DATA_W  transformed word; fixed latency, in order, no backpressure.
- xf_out_valid  in  1  xf_out_data valid.
- stall_cnt  out  32  stats counter; see Optional Feature.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE; rd_ptr = wr_ptr = 0; queue empty; in-flight count 0; err cleared.
  - Reset mid-pass abandons the pass. Memory stays partially rewritten; no done pulse is issued.
- Port arbitration, decided each cycle, highest priority first:
  1. disp_req=1: display read. mem_en=1, mem_we=0, mem_addr=disp_addr.
  2. Write queue non-empty: pop the head. mem_en=1, mem_we=1, address and data come from the queue entry.
  3. State RUN, rd_ptr < FRAME_WORDS and (queue count + in-flight) < WQ_DEPTH: engine read at rd_ptr. Then rd_ptr++ and in-flight++.
  4. Otherwise mem_en=0.
- Read return:
  - Cycle after a display read: disp_valid=1, disp_data=mem_dout.
  - Cycle after an engine read: xf_in_valid=1, xf_in_data=mem_dout.
  - disp_valid and xf_in_valid are never high together.
- Transform return:
  - On xf_out_valid, push {wr_ptr, xf_out_data} into the queue, then wr_ptr++ and in-flight--.
  - In-flight counts words from engine-read issue until xf_out_valid.
  - The credit rule guarantees room. If the queue is nonetheless full, drop the word, set err, and still decrement in-flight.
  - A push and a pop in the same cycle leave the count unchanged. The popped word is the old head.
- FSM:
  - IDLE -> RUN on start. busy=1 from the next cycle.
  - RUN -> DRAIN when rd_ptr == FRAME_WORDS.
  - DRAIN -> DONE when in-flight == 0 and queue empty.
  - DONE: done=1 for one cycle; reset rd_ptr and wr_ptr to 0; -> IDLE.
  - busy = (state != IDLE).
  - start is ignored outside IDLE.
- Display starvation of the engine is permitted: a continuous disp_req simply stalls the pass. The display is never delayed.
- Pointers are ADDR_W wide and never exceed FRAME_WORDS.

Optional Feature:
- Macro: PASS_STATS_EN.
- Defined:
  - stall_cnt increments in RUN or DRAIN on every cycle where the engine had a write pending or a read eligible but disp_req took the port.
  - It clears on rst and on start accepted in IDLE, and saturates at 32'hFFFF_FFFF.
- Undefined: no counter logic; stall_cnt tied to 0.

Test Plan:
- FRAME_WORDS=8, xf = +1 with latency 2, disp_req=0 throughout, start pulse -> words 0..7 each read and rewritten as value+1. done pulses exactly once; busy falls on the cycle after done; err=0.
- disp_req=1 with disp_addr=5 on every cycle of a pass -> disp_valid every cycle with mem[5]; the pass makes no progress. Release disp_req -> the pass completes.
- Alternating disp_req (1,0,...) during a pass -> display reads are never delayed, and no cycle has disp_valid and xf_in_valid both set. Final memory is correct.
- Transform latency 6 with WQ_DEPTH=4 -> at most 4 words outstanding (check the issue count); no err.
- Force an extra xf_out_valid with the queue full -> err=1 and stays 1 until rst.
- rst asserted mid-pass, then start -> the new pass begins at address 0; busy=1 and done=0 until completion. With PASS_STATS_EN, stall_cnt counts the display-won cycles in scenario 3.
